// File: rtl/risk_detect_unit_pkg.sv
// ---------------------------------------------------------------------------
// risk_detect_unit_pkg : shared encodings and constants for the hazard unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package risk_detect_unit_pkg;

  localparam int          CNT_W       = 16;
  localparam int          DRAIN_W     = 2;
  localparam logic [1:0]  DRAIN_DEPTH = 2'd3;
  localparam logic [4:0]  REG_ZERO    = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // $0 is hard-wired, so a write to it can never create a dependency
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != REG_ZERO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/risk_detect_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// risk_sat_counter : up-counter that sticks at all-ones instead of wrapping
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module risk_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/risk_detect_unit.sv
// ---------------------------------------------------------------------------
// risk_detect_unit : pipeline stall/flush/halt control with debug counters
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module risk_detect_unit
  import risk_detect_unit_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_id_branch,
  input  logic             i_id_jump_taken,
  input  logic             i_id_halt,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_reg_write,
  input  logic [4:0]       i_ex_dst,
  input  logic             i_mem_mem_read,
  input  logic [4:0]       i_mem_dst,
  output logic             o_risk,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  state_t             state;
  state_t             state_next;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [DRAIN_W-1:0] drain_cnt_next;

  logic load_use;
  logic branch_alu;
  logic branch_load;
  logic hazard;
  logic stall_inc;
  logic flush_inc;

  assign load_use    = i_ex_mem_read &&
                       (reg_match(i_ex_dst, i_id_rs) ||
                        (i_id_uses_rt && reg_match(i_ex_dst, i_id_rt)));
  assign branch_alu  = i_id_branch && i_ex_reg_write &&
                       (reg_match(i_ex_dst, i_id_rs) || reg_match(i_ex_dst, i_id_rt));
  assign branch_load = i_id_branch && i_mem_mem_read &&
                       (reg_match(i_mem_dst, i_id_rs) || reg_match(i_mem_dst, i_id_rt));
  assign hazard      = load_use || branch_alu || branch_load;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    o_risk         = hazard;
    o_pc_write     = 1'b1;
    o_ifid_write   = 1'b1;
    o_ifid_flush   = 1'b0;
    case (state)
      ST_RUN: begin
        if (hazard) begin
          o_pc_write   = 1'b0;
          o_ifid_write = 1'b0;
        end else if (i_id_halt) begin
          // halt entry squashes the instruction fetched behind the halt
          o_pc_write   = 1'b0;
          o_ifid_flush = 1'b1;
          if (i_enable) begin
            state_next     = ST_DRAIN;
            drain_cnt_next = DRAIN_DEPTH;
          end
        end else if (i_id_jump_taken) begin
          o_ifid_flush = 1'b1;
        end
      end
      ST_DRAIN: begin
        o_risk       = 1'b1;
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        if (i_enable) begin
          if (drain_cnt <= 2'd1) begin
            state_next     = ST_HALTED;
            drain_cnt_next = '0;
          end else begin
            drain_cnt_next = drain_cnt - 2'd1;
          end
        end
      end
      ST_HALTED: begin
        o_risk       = 1'b1;
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
    if (!i_enable) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_ifid_flush = 1'b0;
    end
  end

  assign o_halted  = (state == ST_HALTED);
  assign stall_inc = i_enable && (state == ST_RUN) && hazard;
  assign flush_inc = i_enable && (state == ST_RUN) && !hazard && !i_id_halt && i_id_jump_taken;

  risk_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (i_clk),
    .reset_n (i_reset),
    .inc     (stall_inc),
    .count   (o_stall_count)
  );

  risk_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (i_clk),
    .reset_n (i_reset),
    .inc     (flush_inc),
    .count   (o_flush_count)
  );

endmodule

`default_nettype wire

// File: doc/risk_detect_unit.md
RISK_DETECT_UNIT -- requirements
Module: risk_detect_unit

Interface
REQ-001 i_clk  in  1  single clock; all state updates on rising edge.
REQ-002 i_reset  in  1  synchronous, active-low reset, sampled on i_clk rising edge.
REQ-003 i_enable  in  1  pipeline advance enable from debug unit; 0 = freeze.
REQ-004 i_id_rs, i_id_rt  in  5 each  source registers of instruction in ID.
REQ-005 i_id_uses_rt  in  1  ID instruction reads rt.
REQ-006 i_id_branch  in  1  ID is beq/bne, resolved in ID.
REQ-007 i_id_jump_taken  in  1  ID is a jump, or a branch resolved taken this cycle.
REQ-008 i_id_halt  in  1  ID holds halt.
REQ-009 i_ex_mem_read, i_ex_reg_write  in  1 each; i_ex_dst  in  5  EX-stage load flag, write flag, destination.
REQ-010 i_mem_mem_read  in  1; i_mem_dst  in  5  MEM-stage load flag and destination.
REQ-011 o_risk  out  1  bubble request to control-signal mux.
REQ-012 o_pc_write, o_ifid_write  out  1 each  PC and IF/ID write enables.
REQ-013 o_ifid_flush  out  1  clear IF/ID to NOP.
REQ-014 o_halted  out  1  pipeline drained after halt.
REQ-015 o_stall_count, o_flush_count  out  16 each  saturating debug counters.

Function
REQ-016 Match(x,y) SHALL mean x==y and x!=0.
REQ-017 Load-use: i_ex_mem_read and Match(i_ex_dst, i_id_rs), or Match(i_ex_dst, i_id_rt) with i_id_uses_rt, SHALL raise stall.
REQ-018 Branch-ALU: i_id_branch, i_ex_reg_write, Match(i_ex_dst, rs or rt) SHALL raise stall.
REQ-019 Branch-load: i_id_branch, i_mem_mem_read, Match(i_mem_dst, rs or rt) SHALL raise stall; combined with REQ-017 gives 2 stall cycles for load-then-branch.
REQ-020 Stall SHALL be combinational, same cycle: o_risk=1, o_pc_write=0, o_ifid_write=0, o_ifid_flush=0.
REQ-021 Flush: i_id_jump_taken without stall SHALL give o_ifid_flush=1, o_pc_write=1, o_ifid_write=1, o_risk=0.
REQ-022 Priority: stall > halt entry > flush; flush or halt with pending operand hazard SHALL wait until stall clears.
REQ-023 FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-024 RUN->DRAIN when i_id_halt, no stall, i_enable=1; that cycle o_pc_write=0, o_ifid_flush=1; drain counter loads 3.
REQ-025 DRAIN: o_pc_write=0, o_ifid_write=0, o_risk=1; counter decrements per enabled cycle; at 0 go HALTED.
REQ-026 HALTED: o_halted=1, o_pc_write=0, o_ifid_write=0, o_risk=1; exit only by reset.
REQ-027 i_enable=0: FSM, drain counter and debug counters hold; o_pc_write=0, o_ifid_write=0, o_ifid_flush=0; o_risk follows hazard logic.
REQ-028 o_stall_count SHALL increment per enabled cycle with a REQ-020 stall in RUN; o_flush_count per enabled REQ-021 flush; both saturate at 16'hFFFF, no wrap.
REQ-029 Register 0 SHALL never cause a hazard.

Reset
REQ-030 i_reset=0 at edge: state RUN, drain counter 0, both debug counters 0, o_halted=0.
REQ-031 Reset mid-DRAIN or mid-HALTED SHALL return to RUN next cycle; combinational outputs then follow RUN rules.

Structure
REQ-032 Shared package holds state encodings, drain depth constant (3), counter width (16), register-0 index.
REQ-033 One sub-module, risk_sat_counter, instantiated twice for the debug counters.

Verification
REQ-034 lw $2 in EX, add rs=$2 in ID -> 1 cycle o_risk=1, o_pc_write=0; o_stall_count 0->1.
REQ-035 lw $3 then beq rs=$3 -> 2 consecutive stall cycles, then o_ifid_flush=1 if taken; stall_count=2, flush_count=1.
REQ-036 lw $0 in EX, ID rs=$0 -> no stall.
REQ-037 halt in ID -> flush cycle, 3 DRAIN cycles, then o_halted=1 held 10+ cycles; reset -> RUN, o_halted=0.
REQ-038 i_enable=0 during DRAIN for 5 cycles -> counter frozen, o_halted delayed by 5.
REQ-039 Force 65 540 load-use stalls -> o_stall_count stays 16'hFFFF.
